uart_tx_fifo: RTL

Byte buffer that sits directly upstream of the UART transmitter. It accepts bytes from the bus/register side through a single-cycle write strobe and stores them in a circular FIFO. It then feeds the transmitter one byte at a time on its tx_start/tx_data inputs, using the transmitter's clear_req output as the per-byte completion handshake. Software can therefore queue bursts of bytes without polling the transmitter per byte.

---
 rtl/uart_tx_fifo.sv | 115 +++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular byte FIFO that hands bytes to the UART transmitter
// one at a time, using clear_req as the per-byte completion handshake.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          flush,
   input  logic          clr_overflow,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic          overflow,
   output logic          busy,
   output logic          tx_start,
   output logic [7:0]    tx_data,
   input  logic          clear_req
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push_ok;
   logic            pop_ok;
   logic            drop;
   logic [AW:0]     level_nxt;

   // flush outranks wr_en: a same-cycle write is neither stored nor counted as an overflow
   assign push_ok   = wr_en && !full && !flush;
   assign drop      = wr_en && full && !flush;
   assign pop_ok    = (state == IDLE) && !empty && !flush;
   assign level_nxt = flush ? '0
                    : level + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         level <= level_nxt;
         full  <= (level_nxt == (AW+1)'(DEPTH));
         empty <= (level_nxt == '0);
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (flush) begin
            rd_ptr <= wr_ptr;
         end else if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   // GAP forces at least one low cycle on tx_start before the next byte is popped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop_ok) begin
                  tx_data  <= mem[rd_ptr];
                  tx_start <= 1'b1;
                  busy     <= 1'b1;
                  state    <= SEND;
               end
            end
            SEND: begin
               if (clear_req) begin
                  tx_start <= 1'b0;
                  state    <= GAP;
               end
            end
            GAP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               tx_start <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
